// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among NREQ requesters.
// Each grant runs IDLE -> EXEC (ALU_LAT cycles) -> RESP (held until accepted).
module alu_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_s1,
    input  logic [8*NREQ-1:0] i_req_s2,
    input  logic [3*NREQ-1:0] i_req_func,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [7:0]        o_alu_s1,
    output logic [7:0]        o_alu_s2,
    output logic [2:0]        o_alu_func,
    output logic              o_alu_en,
    input  logic [7:0]        i_alu_result,
    input  logic              i_alu_overflow,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [2:0]        o_rsp_id,
    output logic [7:0]        o_rsp_result,
    output logic              o_rsp_overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [2:0] func_q, func_d;
    logic [7:0] res_q, res_d;
    logic       ovf_q, ovf_d;

    logic            found;
    logic [2:0]      gidx;
    int unsigned     idx;
    logic [NREQ-1:0] ready;
    logic            alu_en;

    // Search upward from ptr with wrap; first valid bit wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                gidx  = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        func_d  = func_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        ready   = '0;
        alu_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready[gidx] = 1'b1;
                    s1_d    = i_req_s1[gidx*8 +: 8];
                    s2_d    = i_req_s2[gidx*8 +: 8];
                    func_d  = i_req_func[gidx*3 +: 3];
                    grant_d = gidx;
                    cnt_d   = 2'(ALU_LAT - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_en = 1'b1;
                if (cnt_q == '0) begin
                    res_d   = i_alu_result;
                    ovf_d   = i_alu_overflow;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == 3'(NREQ - 1)) ? '0 : grant_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            func_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            func_q  <= func_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_req_ready    = ready;
    assign o_alu_en       = alu_en;
    assign o_alu_s1       = s1_q;
    assign o_alu_s2       = s2_q;
    assign o_alu_func     = func_q;
    assign o_rsp_valid    = (state_q == RESP);
    assign o_rsp_id       = grant_q;
    assign o_rsp_result   = res_q;
    assign o_rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [23:0] req_s1, req_s2;
    logic [8:0]  req_func;
    logic        rsp_ready;

    logic [2:0] a_ready, b_ready;
    logic [7:0] a_s1, a_s2, b_s1, b_s2;
    logic [2:0] a_func, b_func;
    logic       a_en, b_en;
    logic [7:0] a_res, b_res;
    logic       a_ovf, b_ovf;
    logic       a_rv, b_rv;
    logic [2:0] a_id, b_id;
    logic [7:0] a_rres, b_rres;
    logic       a_rovf, b_rovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Adder stand-in for the ALU on the latency-1 instance.
    assign {a_ovf, a_res} = {1'b0, a_s1} + {1'b0, a_s2};

    alu_arbiter #(.NREQ(3), .ALU_LAT(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
        .i_req_s1(req_s1), .i_req_s2(req_s2), .i_req_func(req_func),
        .o_req_ready(a_ready), .o_alu_s1(a_s1), .o_alu_s2(a_s2),
        .o_alu_func(a_func), .o_alu_en(a_en), .i_alu_result(a_res),
        .i_alu_overflow(a_ovf), .o_rsp_valid(a_rv), .i_rsp_ready(rsp_ready),
        .o_rsp_id(a_id), .o_rsp_result(a_rres), .o_rsp_overflow(a_rovf)
    );

    alu_arbiter #(.NREQ(3), .ALU_LAT(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
        .i_req_s1(req_s1), .i_req_s2(req_s2), .i_req_func(req_func),
        .o_req_ready(b_ready), .o_alu_s1(b_s1), .o_alu_s2(b_s2),
        .o_alu_func(b_func), .o_alu_en(b_en), .i_alu_result(b_res),
        .i_alu_overflow(b_ovf), .o_rsp_valid(b_rv), .i_rsp_ready(rsp_ready),
        .o_rsp_id(b_id), .o_rsp_result(b_rres), .o_rsp_overflow(b_rovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_s1    = '0;
        req_s2    = '0;
        req_func  = '0;
        rsp_ready = 1'b1;
        b_res     = 8'hEE;
        b_ovf     = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_en", 32'(a_en), 32'h0);
        chk("rst_rv", 32'(a_rv), 32'h0);
        chk("rst_id", 32'(a_id), 32'h0);
        chk("rst_res", 32'(a_rres), 32'h0);
        chk("rst_ovf", 32'(a_rovf), 32'h0);
        chk("rst_s1", 32'(a_s1), 32'h0);
        chk("rst_s2", 32'(a_s2), 32'h0);
        chk("rst_func", 32'(a_func), 32'h0);
        rst_n = 1'b1;

        // Single request from requester 1: 0x12 + 0x34.
        req_valid = 3'b010;
        req_s1    = 24'h00_12_00;
        req_s2    = 24'h00_34_00;
        req_func  = 9'b000_101_000;
        settle();
        chk("single_ready", 32'(a_ready), 32'h2);
        chk("single_idle_en", 32'(a_en), 32'h0);
        tick();
        req_valid = '0;
        settle();
        chk("single_exec_ready", 32'(a_ready), 32'h0);
        chk("single_en", 32'(a_en), 32'h1);
        chk("single_s1", 32'(a_s1), 32'h12);
        chk("single_s2", 32'(a_s2), 32'h34);
        chk("single_func", 32'(a_func), 32'h5);
        tick();
        settle();
        chk("single_rv", 32'(a_rv), 32'h1);
        chk("single_id", 32'(a_id), 32'h1);
        chk("single_res", 32'(a_rres), 32'h46);
        chk("single_ovf", 32'(a_rovf), 32'h0);
        chk("single_resp_en", 32'(a_en), 32'h0);
        tick();
        settle();
        chk("single_done_rv", 32'(a_rv), 32'h0);
        chk("single_hold_s1", 32'(a_s1), 32'h12);

        // Overflow: pointer is at 2, only requester 0 valid -> wraps to 0.
        req_valid = 3'b001;
        req_s1    = 24'h00_00_FF;
        req_s2    = 24'h00_00_01;
        settle();
        chk("ovf_ready", 32'(a_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        settle();
        chk("ovf_id", 32'(a_id), 32'h0);
        chk("ovf_res", 32'(a_rres), 32'h00);
        chk("ovf_flag", 32'(a_rovf), 32'h1);
        tick();

        // Idle with no request: nothing issued.
        tick();
        settle();
        chk("idle_ready", 32'(a_ready), 32'h0);
        chk("idle_en", 32'(a_en), 32'h0);

        // Fairness from reset: order 0,1,2,0,1,2.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 3'b111;
        req_s1    = 24'h30_20_10;
        req_s2    = 24'h03_02_01;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("fair_ready", 32'(a_ready), 32'(3'b001 << (k % 3)));
            tick();
            tick();
            settle();
            chk("fair_id", 32'(a_id), 32'(k % 3));
            chk("fair_res", 32'(a_rres), 32'(8'h11 * ((k % 3) + 1)));
            tick();
        end

        // Backpressure on a grant to requester 0.
        rsp_ready = 1'b0;
        settle();
        chk("bp_ready0", 32'(a_ready), 32'h1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_rv", 32'(a_rv), 32'h1);
            chk("bp_id", 32'(a_id), 32'h0);
            chk("bp_res", 32'(a_rres), 32'h11);
            chk("bp_no_ready", 32'(a_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        settle();
        chk("bp_next_grant", 32'(a_ready), 32'h2);
        tick();
        settle();
        chk("pre_rst_en", 32'(a_en), 32'h1);

        // Reset mid-EXEC.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        settle();
        chk("mrst_en", 32'(a_en), 32'h0);
        chk("mrst_rv", 32'(a_rv), 32'h0);
        chk("mrst_id", 32'(a_id), 32'h0);
        chk("mrst_res", 32'(a_rres), 32'h0);
        chk("mrst_s1", 32'(a_s1), 32'h0);
        tick();
        settle();
        chk("mrst_no_rsp", 32'(a_rv), 32'h0);
        req_valid = 3'b111;
        settle();
        chk("mrst_grant0", 32'(a_ready), 32'h1);

        // ALU_LAT=3 on dut_b; result only correct on the third enable cycle.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 3'b010;
        settle();
        chk("lat3_ready", 32'(b_ready), 32'h2);
        tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                b_res = 8'h22;
                b_ovf = 1'b0;
            end else begin
                b_res = 8'hEE;
                b_ovf = 1'b1;
            end
            settle();
            chk("lat3_en", 32'(b_en), 32'h1);
            chk("lat3_rv_low", 32'(b_rv), 32'h0);
            tick();
        end
        b_res = 8'hEE;
        b_ovf = 1'b1;
        settle();
        chk("lat3_en_off", 32'(b_en), 32'h0);
        chk("lat3_rv", 32'(b_rv), 32'h1);
        chk("lat3_id", 32'(b_id), 32'h1);
        chk("lat3_res", 32'(b_rres), 32'h22);
        chk("lat3_ovf", 32'(b_rovf), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the ALU; legal range 2..8.
REQ-002 Parameter ALU_LAT, default 1: cycles o_alu_en is held before the ALU result is sampled; legal range 1..4.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_req_valid  input  NREQ  per-requester operation request.
REQ-006 i_req_s1  input  8*NREQ  operand 1; requester k occupies bits [8k+7:8k].
REQ-007 i_req_s2  input  8*NREQ  operand 2; same packing as i_req_s1.
REQ-008 i_req_func  input  3*NREQ  function code; requester k occupies bits [3k+2:3k].
REQ-009 o_req_ready  output  NREQ  one-hot accept strobe; requester k's operands are taken in the cycle bit k is high.
REQ-010 o_alu_s1, o_alu_s2  output  8 each  latched operands to the shared ALU.
REQ-011 o_alu_func  output  3  latched function code to the ALU.
REQ-012 o_alu_en  output  1  ALU enable.
REQ-013 i_alu_result  input  8  ALU result.
REQ-014 i_alu_overflow  input  1  ALU carry/overflow.
REQ-015 o_rsp_valid  output  1  response available.
REQ-016 i_rsp_ready  input  1  consumer accepts response.
REQ-017 o_rsp_id  output  3  index of the requester owning the response.
REQ-018 o_rsp_result  output  8  captured ALU result.
REQ-019 o_rsp_overflow  output  1  captured ALU overflow.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP.
REQ-021 In IDLE, when any i_req_valid bit is set, the grant SHALL go to the first set bit found searching upward from the round-robin pointer ptr, wrapping NREQ-1 -> 0.
REQ-022 In that same IDLE cycle, o_req_ready SHALL be high on the granted bit only; the operands, func and grant index are registered; next state is EXEC.
REQ-023 o_req_ready SHALL be all-zero in EXEC and RESP, and in IDLE with no valid request.
REQ-024 In EXEC, o_alu_en SHALL be 1 for exactly ALU_LAT cycles, driven by a down-counter loaded with ALU_LAT-1.
REQ-025 On the last EXEC cycle, i_alu_result and i_alu_overflow SHALL be captured into o_rsp_result/o_rsp_overflow; next state is RESP.
REQ-026 In RESP, o_rsp_valid=1 and o_rsp_id=grant; result, id and overflow SHALL remain stable until i_rsp_ready=1.
REQ-027 On RESP with i_rsp_ready=1: next state is IDLE, ptr <= grant+1 mod NREQ.
REQ-028 Minimum issue-to-issue period SHALL be ALU_LAT+2 cycles; IDLE always takes at least one cycle.
REQ-029 With no valid request, the block SHALL stay in IDLE with ptr unchanged.
REQ-030 A requester SHALL hold valid and operands until ready; deasserting earlier means no operation for that requester and no error.
REQ-031 i_req_valid changes during EXEC/RESP SHALL have no effect on the operation in flight.
REQ-032 o_alu_s1/s2/func SHALL hold the latched values outside EXEC; the ALU is gated only by o_alu_en.
REQ-033 Arithmetic is owned by the ALU; the block SHALL pass 8-bit results and overflow through unmodified.

Reset
REQ-034 With i_rst_n=0 at a clock edge: state=IDLE, ptr=0, counter=0, o_alu_en=0, o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_overflow=0, o_alu_s1=o_alu_s2=0, o_alu_func=0.
REQ-035 Reset in EXEC or RESP SHALL abandon the operation and emit no response.
REQ-036 The first grant after reset SHALL favour requester 0.

Verification
REQ-037 Single request: NREQ=3, ALU_LAT=1, req1 valid, s1=0x12, s2=0x34, rsp_ready=1 -> ready[1] for 1 cycle, en for 1 cycle, rsp_valid with id=1, result=0x46, ovf=0; 3 cycles total.
REQ-038 Overflow: s1=0xFF, s2=0x01 -> result=0x00, ovf=1.
REQ-039 Fairness: all three requesters valid continuously -> grant order 0,1,2,0,1,2; ptr wraps 2->0.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid held, result/id stable, no ready pulses; one cycle after rsp_ready=1, IDLE grants the next requester.
REQ-041 ALU_LAT=3: o_alu_en high exactly 3 cycles; result sampled on the 3rd cycle.
REQ-042 Reset mid-EXEC: i_rst_n=0 for one edge -> all outputs 0, no response; next grant goes to requester 0.
